bytebeat_sequencer: RTL and testbench

//  Controller for the bytebeat generator: paces sample consumption at a fixed audio rate and

---
 rtl/bytebeat_pkg.sv | 19 +
 rtl/bytebeat_tick_div.sv | 29 ++
 rtl/bytebeat_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bytebeat_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bytebeat_pkg.sv
// Shared types and constants for the bytebeat sequencer and its tick divider.
package bytebeat_pkg;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
    } preset_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } seq_state_t;

    localparam logic [15:0] PRESET_RESET = 16'h573A;

endpackage

// File: rtl/bytebeat_tick_div.sv
// Sample-rate divider: one-cycle tick every CLK_DIV clocks, held at zero while clr is high.
module bytebeat_tick_div #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

    // Gated by clr so a count left at LAST on the way into IDLE cannot fire a stray tick.
    assign tick = !clr && (count_q == LAST);

endmodule

// File: rtl/bytebeat_sequencer.sv
// Bytebeat controller: paces sample consumption and steps parameter presets into the generator.
// Optional BYTEBEAT_SEQ_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module bytebeat_sequencer
    import bytebeat_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned STEP_SAMPLES = 4096,
    parameter int unsigned NUM_PRESETS  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_PRESETS)-1:0] cfg_idx,
    input  logic [15:0]                    cfg_data,
    output logic [3:0]                     a_s,
    output logic [3:0]                     b_s,
    output logic [3:0]                     c_s,
    output logic [3:0]                     d_s,
    output logic                           a_s_vld,
    output logic                           b_s_vld,
    output logic                           c_s_vld,
    output logic                           d_s_vld,
    input  logic                           a_s_rdy,
    input  logic                           b_s_rdy,
    input  logic                           c_s_rdy,
    input  logic                           d_s_rdy,
    input  logic [7:0]                     smp_in,
    input  logic                           smp_in_vld,
    output logic                           smp_in_rdy,
    output logic [7:0]                     sample_out,
    output logic                           sample_tick,
    output logic [$clog2(NUM_PRESETS)-1:0] preset_idx,
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
    output logic [15:0]                    underrun_cnt,
`endif
    output logic                           underrun
);

    localparam int unsigned IDX_W  = $clog2(NUM_PRESETS);
    localparam int unsigned SCNT_W = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_SAMPLES - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [3:0]        vld_q, vld_d;
    preset_t           chan_q, chan_d;
    preset_t           table_q [NUM_PRESETS];
    logic [3:0]        rdy;
    logic              tick;
    logic [7:0]        sample_out_q;
    logic              sample_tick_q;
    logic              underrun_q;

    bytebeat_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .reset(reset),
        .clr  (state_q == IDLE),
        .tick (tick)
    );

    assign rdy      = {a_s_rdy, b_s_rdy, c_s_rdy, d_s_rdy};
    assign idx_next = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        vld_d   = vld_q;
        chan_d  = chan_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                    vld_d   = 4'b1111;
                    chan_d  = table_q[idx_q];
                end
            end
            LOAD: begin
                // Outstanding channels finish their handshake even when enable drops.
                vld_d = vld_q & ~rdy;
                if (vld_d == 4'b0000) begin
                    state_d = enable ? RUN : IDLE;
                    scnt_d  = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        state_d = LOAD;
                        idx_d   = idx_next;
                        scnt_d  = '0;
                        vld_d   = 4'b1111;
                        chan_d  = table_q[idx_next];
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            scnt_q  <= '0;
            vld_q   <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            vld_q   <= vld_d;
            chan_q  <= chan_d;
        end
    end

    // Reads in the LOAD-entry cycle see the pre-write entry, so a same-cycle write is not latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PRESETS; i++) begin
                table_q[i] <= preset_t'(PRESET_RESET);
            end
        end else if (cfg_we) begin
            table_q[cfg_idx] <= preset_t'(cfg_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out_q  <= '0;
            sample_tick_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            sample_tick_q <= tick && smp_in_vld;
            underrun_q    <= tick && !smp_in_vld;
            if (tick && smp_in_vld) begin
                sample_out_q <= smp_in;
            end
        end
    end

`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && state_d == LOAD)) begin
            urun_cnt_q <= '0;
        end else if (tick && !smp_in_vld && urun_cnt_q != 16'hFFFF) begin
            urun_cnt_q <= urun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = urun_cnt_q;
`endif

    assign smp_in_rdy  = tick;
    assign sample_out  = sample_out_q;
    assign sample_tick = sample_tick_q;
    assign underrun    = underrun_q;
    assign preset_idx  = idx_q;
    assign a_s         = chan_q.a;
    assign b_s         = chan_q.b;
    assign c_s         = chan_q.c;
    assign d_s         = chan_q.d;
    assign a_s_vld     = vld_q[3];
    assign b_s_vld     = vld_q[2];
    assign c_s_vld     = vld_q[1];
    assign d_s_vld     = vld_q[0];

endmodule

// File: tb/tb_bytebeat_sequencer.sv
// Directed bench for bytebeat_sequencer (CLK_DIV=4, STEP_SAMPLES=8, NUM_PRESETS=4).
module tb_bytebeat_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, cfg_we;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_data;
    logic [3:0]  a_s, b_s, c_s, d_s;
    logic        a_s_vld, b_s_vld, c_s_vld, d_s_vld;
    logic        a_s_rdy, b_s_rdy, c_s_rdy, d_s_rdy;
    logic [7:0]  smp_in, sample_out;
    logic        smp_in_vld, smp_in_rdy, sample_tick, underrun;
    logic [1:0]  preset_idx;
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    bytebeat_sequencer #(
        .CLK_DIV     (4),
        .STEP_SAMPLES(8),
        .NUM_PRESETS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_data   (cfg_data),
        .a_s        (a_s),
        .b_s        (b_s),
        .c_s        (c_s),
        .d_s        (d_s),
        .a_s_vld    (a_s_vld),
        .b_s_vld    (b_s_vld),
        .c_s_vld    (c_s_vld),
        .d_s_vld    (d_s_vld),
        .a_s_rdy    (a_s_rdy),
        .b_s_rdy    (b_s_rdy),
        .c_s_rdy    (c_s_rdy),
        .d_s_rdy    (d_s_rdy),
        .smp_in     (smp_in),
        .smp_in_vld (smp_in_vld),
        .smp_in_rdy (smp_in_rdy),
        .sample_out (sample_out),
        .sample_tick(sample_tick),
        .preset_idx (preset_idx),
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    logic [15:0] chans;
    logic [3:0]  vlds;
    assign chans = {a_s, b_s, c_s, d_s};
    assign vlds  = {a_s_vld, b_s_vld, c_s_vld, d_s_vld};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       vld;
        logic [7:0] smp;
        logic [7:0] exp_out;
        logic       exp_tick;
        logic       exp_urun;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until preset_idx leaves 'from' (bounded), returning the number of clocks taken.
    task automatic wait_preset_change(input logic [1:0] from, output int n);
        n = 0;
        while (preset_idx == from && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!smp_in_rdy && n < 8) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic [15:0] exp_ch [4];

        vecs[0] = '{1'b1, 8'h10, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h21, 8'h21, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'hFF, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h7F, 8'h7F, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h55, 8'h7F, 1'b0, 1'b1};
        exp_ch[0] = 16'h1111;
        exp_ch[1] = 16'h2222;
        exp_ch[2] = 16'h3333;
        exp_ch[3] = 16'h4444;

        reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
        a_s_rdy = 1'b1; b_s_rdy = 1'b1; c_s_rdy = 1'b1; d_s_rdy = 1'b1;
        smp_in = '0; smp_in_vld = 1'b0;
        repeat (3) step();
        check("reset_chans", 32'(chans), 32'h0);
        check("reset_vld", 32'(vlds), 32'h0);
        check("reset_misc", 32'({sample_out, sample_tick, underrun, smp_in_rdy, preset_idx}), 32'h0);
        reset = 1'b0;
        step();
        check("idle_no_rdy", 32'(smp_in_rdy), 32'h0);

        // Program the table in IDLE.
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_idx = 2'(i); cfg_data = exp_ch[i];
            step();
        end
        cfg_we = 1'b0;

        enable = 1'b1; smp_in_vld = 1'b1;
        step();
        check("load0_chans", 32'(chans), 32'h1111);
        check("load0_vld", 32'(vlds), 32'hF);
        check("load0_idx", 32'(preset_idx), 32'h0);
        step();
        check("run0_vld", 32'(vlds), 32'h0);
        check("run0_chans_hold", 32'(chans), 32'h1111);

        // One vector per sample tick; the 8th tick ends the preset.
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!smp_in_rdy && n < 8) begin
                step();
                n++;
                if (!smp_in_rdy) begin
                    check($sformatf("pulse_width_%0d", i), 32'({sample_tick, underrun}), 32'h0);
                end
            end
            if (i > 0) check($sformatf("tick_gap_%0d", i), 32'(n + 1), 32'd4);
            else check("first_tick_lat", 32'(n), 32'd2);
            smp_in_vld = vecs[i].vld;
            smp_in     = vecs[i].smp;
            step();
            check($sformatf("vec%0d_out", i), 32'(sample_out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_tick", i), 32'(sample_tick), 32'(vecs[i].exp_tick));
            check($sformatf("vec%0d_urun", i), 32'(underrun), 32'(vecs[i].exp_urun));
            check($sformatf("vec%0d_rdy_low", i), 32'(smp_in_rdy), 32'h0);
        end
        check("adv1_idx", 32'(preset_idx), 32'h1);
        check("adv1_chans", 32'(chans), 32'h2222);
        check("adv1_vld", 32'(vlds), 32'hF);

        smp_in_vld = 1'b1;
        for (int p = 2; p <= 4; p++) begin
            wait_preset_change(2'(p - 1), n);
            check($sformatf("preset_period_%0d", p & 3), 32'(n), 32'd32);
            check($sformatf("preset_idx_%0d", p & 3), 32'(preset_idx), 32'(p & 3));
            check($sformatf("preset_chans_%0d", p & 3), 32'(chans), 32'(exp_ch[p & 3]));
        end

        // Reset in RUN: outputs clear at once, table reverts to defaults.
        repeat (6) step();
        reset = 1'b1;
        step();
        check("rst_run_chans", 32'(chans), 32'h0);
        check("rst_run_vld", 32'(vlds), 32'h0);
        check("rst_run_misc", 32'({sample_out, sample_tick, underrun, smp_in_rdy, preset_idx}), 32'h0);
        reset = 1'b0; b_s_rdy = 1'b0;
        step();
        check("default_chans", 32'(chans), 32'h573A);
        check("default_vld", 32'(vlds), 32'hF);

        // b channel stalls for 11 clocks; ticks keep firing in LOAD.
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (smp_in_rdy) pulses++;
            check($sformatf("bstall_vld_%0d", k), 32'(vlds), 32'h4);
            check($sformatf("bstall_b_%0d", k), 32'(b_s), 32'h7);
        end
        check("bstall_ticks", 32'(pulses), 32'd3);
        check("bstall_idx", 32'(preset_idx), 32'h0);
        b_s_rdy = 1'b1;
        step();
        check("bstall_done_vld", 32'(vlds), 32'h0);
        wait_preset_change(2'h0, n);
        check("load_ticks_uncounted", 32'(n), 32'd32);
        check("default_chans_1", 32'(chans), 32'h573A);

        // enable drops mid-LOAD with d stalled.
        enable = 1'b0; d_s_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("dstall_vld_%0d", k), 32'(vlds), 32'h1);
            check($sformatf("dstall_d_%0d", k), 32'(d_s), 32'hA);
        end
        d_s_rdy = 1'b1;
        step();
        check("dstall_done_vld", 32'(vlds), 32'h0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (smp_in_rdy) pulses++;
        end
        check("idle_no_ticks", 32'(pulses), 32'd0);
        check("idle_idx_kept", 32'(preset_idx), 32'h1);

        // Re-entry keeps preset 1; a same-cycle write to it is not latched.
        enable = 1'b1; cfg_we = 1'b1; cfg_idx = 2'h1; cfg_data = 16'hBEEF;
        step();
        cfg_we = 1'b0;
        check("reentry_idx", 32'(preset_idx), 32'h1);
        check("reentry_old_value", 32'(chans), 32'h573A);
        wait_rdy(n);
        check("div_cleared", 32'(n), 32'd3);
        check("chans_undisturbed", 32'(chans), 32'h573A);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        check("new_value_loaded", 32'(chans), 32'hBEEF);
        check("new_value_vld", 32'(vlds), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
